// File: rtl/lcd_host_seq.sv
// lcd_host_seq: queued command sequencer for an LCD display controller, plus
// capture, checksum and readback of the image the controller writes back.
module lcd_host_seq #(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned GUARD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [3:0]  push_cmd,
   output logic        full,
   output logic [3:0]  cmd,
   output logic        cmd_valid,
   input  logic        busy,
   input  logic        done,
   input  logic        IRAM_valid,
   input  logic [5:0]  IRAM_A,
   input  logic [7:0]  IRAM_D,
   input  logic [5:0]  rb_addr,
   output logic [7:0]  rb_data,
   output logic        finished,
   output logic [6:0]  wr_count,
   output logic [13:0] checksum,
   output logic [3:0]  err
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   typedef enum logic [2:0] {BOOT, IDLE, ISSUE, GUARD, WAIT, DRAIN, FIN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic [3:0]      cmd_q, cmd_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
   logic            finished_q, finished_d;
   logic [6:0]      wr_count_q, wr_count_d;
   logic [13:0]     checksum_q, checksum_d;
   logic [3:0]      err_q, err_d;
   logic [63:0]     written_q, written_d;
   logic [7:0]      rb_data_q;

   logic [3:0]      fifo_mem [FIFO_DEPTH];
   logic [7:0]      img_mem  [64];

   logic            pop, do_push, empty, guard_last;
   logic [3:0]      head;

   assign empty      = (count_q == '0);
   assign head       = fifo_mem[rd_ptr_q];
   assign do_push    = push && (!full_q || pop);
   assign guard_last = (GUARD_CYCLES <= 1) || (guard_cnt_q == GW'(GUARD_CYCLES - 1));

   // Sequencer next state: issue one queued command per handshake with the controller.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      guard_cnt_d = guard_cnt_q;
      finished_d  = finished_q;
      case (state_q)
         BOOT:  if (!busy) state_d = IDLE;
         IDLE:  if (!empty && !busy) state_d = ISSUE;
         ISSUE: begin
            // A late busy holds the issue so cmd_valid never lands on a busy edge.
            if (!busy) begin
               pop = 1'b1;
               if (head >= 4'd12) begin
                  state_d = IDLE;
               end else begin
                  cmd_d       = head;
                  cmd_valid_d = 1'b1;
                  guard_cnt_d = '0;
                  state_d     = GUARD;
               end
            end
         end
         GUARD: begin
            if (guard_last) state_d = (cmd_q == 4'd0) ? DRAIN : WAIT;
            else            guard_cnt_d = guard_cnt_q + GW'(1);
         end
         WAIT:  if (!busy) state_d = IDLE;
         DRAIN: begin
            if (done) begin
               state_d    = FIN;
               finished_d = 1'b1;
            end
         end
         FIN:     ;
         default: state_d = BOOT;
      endcase
   end

   // Queue pointer and occupancy next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(FIFO_DEPTH));
   end

   // Write-back statistics and sticky error flags; a same-cycle write counts before the done check.
   always_comb begin
      wr_count_d = wr_count_q;
      checksum_d = checksum_q;
      err_d      = err_q;
      written_d  = written_q;
      if (push && !do_push) err_d[0] = 1'b1;
      if (IRAM_valid) begin
         if (wr_count_q != 7'd127) wr_count_d = wr_count_q + 7'd1;
         checksum_d = checksum_q + 14'(IRAM_D);
         if (written_q[IRAM_A]) err_d[2] = 1'b1;
         written_d[IRAM_A] = 1'b1;
         if (state_q != DRAIN) err_d[3] = 1'b1;
      end
      if ((state_q == DRAIN) && done && (wr_count_d != 7'd64)) err_d[1] = 1'b1;
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         cmd_q       <= 4'd0;
         cmd_valid_q <= 1'b0;
         guard_cnt_q <= '0;
         finished_q  <= 1'b0;
         wr_count_q  <= 7'd0;
         checksum_q  <= 14'd0;
         err_q       <= 4'd0;
         written_q   <= 64'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         guard_cnt_q <= guard_cnt_d;
         finished_q  <= finished_d;
         wr_count_q  <= wr_count_d;
         checksum_q  <= checksum_d;
         err_q       <= err_d;
         written_q   <= written_d;
      end
   end

   // Storage arrays carry no reset; occupancy and written marks track validity.
   always_ff @(posedge clk) begin
      if (do_push)    fifo_mem[wr_ptr_q] <= push_cmd;
      if (IRAM_valid) img_mem[IRAM_A]    <= IRAM_D;
   end

   // Registered readback; a same-cycle write to rb_addr returns the old byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rb_data_q <= 8'd0;
      else       rb_data_q <= img_mem[rb_addr];
   end

   assign full      = full_q;
   assign cmd       = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign finished  = finished_q;
   assign wr_count  = wr_count_q;
   assign checksum  = checksum_q;
   assign err       = err_q;
   assign rb_data   = rb_data_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb_lcd_host_seq: directed scenarios with randomized codes, data and controller
// busy lengths, checked against queue/array/sum models of the sequencer.
module tb_lcd_host_seq;
   logic        clk = 1'b0;
   logic        reset;
   logic        push;
   logic [3:0]  push_cmd;
   logic        full;
   logic [3:0]  cmd;
   logic        cmd_valid;
   logic        busy;
   logic        done;
   logic        busy_boot;
   logic        busy_ctrl = 1'b0;
   logic        IRAM_valid;
   logic [5:0]  IRAM_A;
   logic [7:0]  IRAM_D;
   logic [5:0]  rb_addr;
   logic [7:0]  rb_data;
   logic        finished;
   logic [6:0]  wr_count;
   logic [13:0] checksum;
   logic [3:0]  err;

   int   total = 0;
   int   bad = 0;
   int   issued[$];
   int   viol = 0;
   int   busy_len = 0;
   int   ctrl_cnt = 0;
   logic busy_edge;

   assign busy = busy_boot | busy_ctrl;

   lcd_host_seq #(.FIFO_DEPTH(16), .GUARD_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .push(push), .push_cmd(push_cmd), .full(full),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
      .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
      .rb_addr(rb_addr), .rb_data(rb_data), .finished(finished),
      .wr_count(wr_count), .checksum(checksum), .err(err)
   );

   always #5 clk = ~clk;

   // Log every issued command and flag any issue made on an edge where busy was high.
   always @(posedge clk) begin
      busy_edge = busy;
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
         issued.push_back(int'(cmd));
         if (busy_edge === 1'b1) viol++;
      end
   end

   // Controller model: raise busy for busy_len cycles after each accepted command.
   always @(negedge clk) begin
      if (reset === 1'b1) ctrl_cnt = 0;
      else begin
         if (ctrl_cnt > 0) ctrl_cnt--;
         if (cmd_valid === 1'b1) ctrl_cnt = busy_len;
      end
      busy_ctrl = (ctrl_cnt > 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [3:0] c);
      push = 1'b1;
      push_cmd = c;
      step();
      push = 1'b0;
   endtask

   task automatic iram_write(input logic [5:0] a, input logic [7:0] d, input logic dn);
      IRAM_valid = 1'b1;
      IRAM_A = a;
      IRAM_D = d;
      done = dn;
      step();
      IRAM_valid = 1'b0;
      done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_issued(input int n, input int budget, input string tag);
      for (int k = 0; k < budget && issued.size() < n; k++) step();
      chk(tag, 32'(issued.size() >= n), 32'd1);
   endtask

   initial begin
      int          base;
      int          exp_q[$];
      int          n;
      int          sum;
      int          perm[64];
      int          j;
      int          tmp;
      logic [3:0]  c;
      logic [7:0]  d;
      logic [5:0]  a;
      logic [7:0]  mem_m [64];

      reset = 1'b1; push = 1'b0; push_cmd = 4'd0; done = 1'b0; busy_boot = 1'b0;
      IRAM_valid = 1'b0; IRAM_A = 6'd0; IRAM_D = 8'd0; rb_addr = 6'd0;

      // Reset values
      step();
      step();
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_finished", 32'(finished), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_checksum", 32'(checksum), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rb_data", 32'(rb_data), 32'd0);
      reset = 1'b0;

      // Boot: controller busy for 70 cycles with {1,5} queued
      busy_boot = 1'b1;
      do_reset();
      base = issued.size();
      push_one(4'd1);
      push_one(4'd5);
      for (int k = 0; k < 68; k++) step();
      chk("boot_no_issue", 32'(issued.size() - base), 32'd0);
      busy_len = int'($urandom_range(1, 6));
      busy_boot = 1'b0;
      wait_issued(base + 2, 100, "boot_timeout");
      chk("boot_first", 32'(issued[base]), 32'd1);
      chk("boot_second", 32'(issued[base + 1]), 32'd5);
      step();
      step();
      chk("cmd_hold", 32'({cmd_valid, cmd}), 32'h05);

      // Overflow: 17 pushes into a 16-deep queue held in boot
      busy_boot = 1'b1;
      do_reset();
      base = issued.size();
      exp_q.delete();
      for (int i = 0; i < 17; i++) begin
         c = 4'($urandom_range(1, 15));
         push_one(c);
         if (i < 16 && c < 4'd12) exp_q.push_back(int'(c));
         if (i == 14) chk("ovf_full_15", 32'(full), 32'd0);
         if (i == 15) chk("ovf_full_16", 32'(full), 32'd1);
      end
      chk("ovf_err", 32'(err), 32'h1);
      n = exp_q.size();
      busy_len = int'($urandom_range(1, 5));
      busy_boot = 1'b0;
      wait_issued(base + n, 600, "ovf_timeout");
      for (int i = 0; i < n; i++) chk("ovf_order", 32'(issued[base + i]), 32'(exp_q[i]));
      for (int k = 0; k < 30; k++) step();
      chk("ovf_no_17th", 32'(issued.size() - base), 32'(n));
      chk("ovf_empty_full", 32'(full), 32'd0);

      // Full image write-back in shuffled order, last write together with done
      busy_len = 0;
      do_reset();
      base = issued.size();
      push_one(4'd0);
      wait_issued(base + 1, 20, "img_timeout");
      chk("img_cmd", 32'(issued[base]), 32'd0);
      step();
      for (int i = 0; i < 64; i++) perm[i] = i;
      for (int i = 63; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      sum = 0;
      for (int i = 0; i < 64; i++) begin
         a = 6'(perm[i]);
         mem_m[a] = 8'(perm[i]);
         sum += perm[i];
         iram_write(a, 8'(perm[i]), 1'(i == 63));
      end
      chk("img_finished", 32'(finished), 32'd1);
      chk("img_wr_count", 32'(wr_count), 32'd64);
      chk("img_checksum", 32'(checksum), 32'(sum % 16384));
      chk("img_err", 32'(err), 32'd0);
      rb_addr = 6'd37;
      step();
      chk("img_rb_37", 32'(rb_data), 32'd37);
      for (int k = 0; k < 4; k++) begin
         a = 6'($urandom);
         rb_addr = a;
         step();
         chk("img_rb_rand", 32'(rb_data), 32'(mem_m[a]));
      end
      base = issued.size();
      push_one(4'd3);
      for (int k = 0; k < 10; k++) step();
      chk("fin_no_issue", 32'(issued.size() - base), 32'd0);
      chk("fin_hold", 32'(finished), 32'd1);

      // Short image with a duplicate address
      do_reset();
      base = issued.size();
      push_one(4'd0);
      wait_issued(base + 1, 20, "dup_timeout");
      step();
      sum = 0;
      j = int'($urandom_range(6, 61));
      for (int i = 0; i < 62; i++) begin
         d = 8'($urandom);
         mem_m[i] = d;
         sum += int'(d);
         iram_write(6'(i), d, 1'b0);
         if (i == j) begin
            d = 8'($urandom);
            mem_m[5] = d;
            sum += int'(d);
            iram_write(6'd5, d, 1'b0);
         end
      end
      done = 1'b1;
      step();
      done = 1'b0;
      chk("dup_err", 32'(err), 32'h6);
      chk("dup_finished", 32'(finished), 32'd1);
      chk("dup_wr_count", 32'(wr_count), 32'd63);
      chk("dup_checksum", 32'(checksum), 32'(sum % 16384));
      rb_addr = 6'd5;
      step();
      chk("dup_rb_5", 32'(rb_data), 32'(mem_m[5]));

      // Reserved code skipped; stray write-back while waiting on the controller
      busy_len = int'($urandom_range(4, 8));
      do_reset();
      base = issued.size();
      push_one(4'd13);
      push_one(4'd2);
      wait_issued(base + 1, 30, "skip_timeout");
      chk("skip_first", 32'(issued[base]), 32'd2);
      d = 8'($urandom);
      iram_write(6'($urandom), d, 1'b0);
      step();
      chk("stray_err", 32'(err), 32'h8);
      chk("stray_wr_count", 32'(wr_count), 32'd1);
      chk("stray_checksum", 32'(checksum), 32'(d));
      for (int k = 0; k < 20; k++) step();
      chk("skip_count", 32'(issued.size() - base), 32'd1);

      // Reset on the cmd_valid cycle aborts and clears the queue
      busy_len = 0;
      do_reset();
      push_one(4'd7);
      push_one(4'd9);
      for (int k = 0; k < 20 && cmd_valid !== 1'b1; k++) step();
      chk("abort_seen", 32'(cmd_valid), 32'd1);
      reset = 1'b1;
      step();
      chk("abort_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("abort_cmd", 32'(cmd), 32'd0);
      chk("abort_finished", 32'(finished), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      reset = 1'b0;
      base = issued.size();
      for (int k = 0; k < 20; k++) step();
      chk("abort_queue_clear", 32'(issued.size() - base), 32'd0);

      chk("busy_rule", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lcd_host_seq.md
LCD_HOST_SEQ -- requirements
Module: lcd_host_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, command queue entries (power of 2, 4..64).
REQ-002 SHALL have parameter GUARD_CYCLES, default 1, cycles after each cmd_valid before busy is sampled.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports push  in  1 and push_cmd  in  4: enqueue push_cmd when push=1.
REQ-006 SHALL have port full  out  1: queue holds FIFO_DEPTH entries.
REQ-007 SHALL have ports cmd  out  4 and cmd_valid  out  1: command to the display controller.
REQ-008 SHALL have ports busy  in  1 and done  in  1: controller status.
REQ-009 SHALL have ports IRAM_valid  in  1, IRAM_A  in  6 and IRAM_D  in  8: image write-back from the controller.
REQ-010 SHALL have ports rb_addr  in  6 and rb_data  out  8: captured-image readback.
REQ-011 SHALL have ports finished  out  1, wr_count  out  7 and checksum  out  14.
REQ-012 SHALL have port err  out  4: sticky flags {proto, dup, count, overflow} (bit3..bit0).

Function
REQ-013 SHALL run a FIFO of 4-bit commands; push while full drops the entry and sets err[0]; push and pop in the same cycle while full is accepted.
REQ-014 SHALL use states BOOT, IDLE, ISSUE, GUARD, WAIT, DRAIN, FIN.
REQ-015 BOOT: SHALL stay until busy=0 (controller image load), then go to IDLE.
REQ-016 IDLE: SHALL go to ISSUE when the queue is non-empty and busy=0.
REQ-017 ISSUE: SHALL pop one entry; for codes 12..15, no cmd_valid and return to IDLE; otherwise drive cmd=entry with cmd_valid=1 for exactly one cycle, then go to GUARD.
REQ-018 GUARD: SHALL hold GUARD_CYCLES cycles, then go to DRAIN if the issued code was 0 (write), else WAIT.
REQ-019 WAIT: SHALL return to IDLE on the first cycle with busy=0.
REQ-020 DRAIN: SHALL go to FIN on done=1.
REQ-021 FIN: SHALL assert finished=1, ignore queued entries, and hold until reset; push is still accepted into the queue.
REQ-022 cmd_valid SHALL never be asserted while busy=1 was sampled in the same cycle; cmd SHALL hold its last value when cmd_valid=0.
REQ-023 Each cycle with IRAM_valid=1 SHALL write IRAM_D to mem[IRAM_A] (64x8).
REQ-024 Each such cycle SHALL increment wr_count, saturating at 127.
REQ-025 Each such cycle SHALL add IRAM_D to checksum (14-bit, wraps modulo 2^14).
REQ-026 A write to an address already written since reset SHALL still be stored and SHALL set err[2].
REQ-027 IRAM_valid=1 in any state other than DRAIN SHALL still be captured and SHALL set err[3].
REQ-028 On done=1 in DRAIN, wr_count!=64 SHALL set err[1].
REQ-029 rb_data SHALL equal mem[rb_addr] registered, with 1-cycle latency; a same-cycle IRAM write to that address returns the old data.
REQ-030 Simultaneous done=1 and IRAM_valid=1 SHALL capture the write before the count check, so the count check includes that write.

Reset
REQ-031 Reset SHALL set state=BOOT, queue empty, full=0, cmd=0, cmd_valid=0, finished=0, wr_count=0, checksum=0, err=0, rb_data=0, and clear all written-address marks; mem contents are undefined.
REQ-032 Reset asserted mid-operation SHALL abort immediately; cmd_valid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-033 Scenario: busy=1 for 70 cycles after reset, queue preloaded {1,5} -> no cmd_valid before busy falls; then cmd=1 pulse, and cmd=5 only after busy returns low.
REQ-034 Scenario: push 17 entries with no pops (FIFO_DEPTH=16) -> full=1 after 16 pushes, err=4'b0001, 17th entry absent from issue order.
REQ-035 Scenario: issue 0, controller writes addresses 0..63 with D=addr then pulses done -> finished=1, wr_count=64, checksum=2016, err=0, rb_addr=37 gives rb_data=37 one cycle later.
REQ-036 Scenario: 63 writes with address 5 repeated, then done -> err[2]=1, err[1]=1, finished=1.
REQ-037 Scenario: queue {13,2} -> no cmd_valid for 13, cmd=2 issued; an IRAM_valid pulse during WAIT sets err[3].
REQ-038 Scenario: reset asserted on the cmd_valid cycle -> outputs at reset values next cycle, state BOOT.
